// File: rtl/m68k_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | m68k_bus_pkg - shared state codes, FC values and types for the bus master
// | rev 1.0
// +----------------------------------------------------------------------+
package m68k_bus_pkg;

  localparam int TMO_W = 8;

  localparam logic [2:0] FC_SUP_DATA = 3'b101;
  localparam logic [2:0] FC_IACK     = 3'b111;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ARB    = 3'd1;
  localparam state_t ST_ADDR   = 3'd2;
  localparam state_t ST_STROBE = 3'd3;
  localparam state_t ST_WDS    = 3'd4;
  localparam state_t ST_WAIT   = 3'd5;
  localparam state_t ST_END    = 3'd6;
  localparam state_t ST_REL    = 3'd7;

  typedef struct packed {
    logic        rw;
    logic [22:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        hold;
  } req_t;

  // Data strobes are active-low images of the {upper,lower} byte enables.
  function automatic logic [1:0] be_to_ds(input logic [1:0] be);
    return ~be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/m68k_bus_master_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync2 - two-flop synchronizer for active-low bus inputs, resets to 1
// | rev 1.0
// +----------------------------------------------------------------------+
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/m68k_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | m68k_bus_master - secondary 68000 bus initiator with BR/BG/BGACK arbitration
// | rev 1.0
// +----------------------------------------------------------------------+
module m68k_bus_master
  import m68k_bus_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [2:0] FC_CODE        = FC_SUP_DATA
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        REQ_RW,
  input  logic [22:0] REQ_ADDR,
  input  logic [1:0]  REQ_BE,
  input  logic [15:0] REQ_WDATA,
  input  logic        REQ_HOLD,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic [22:0] ADDR,
  output logic [15:0] DATA_OUT,
  input  logic [15:0] DATA_IN,
  output logic        DATA_OE,
  output logic        BUS_OE,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic [2:0]  FC,
  input  logic        AS_IN,
  input  logic        DTACK,
  input  logic        BERR,
  output logic        BR,
  input  logic        BG,
  output logic        BGACK
);

  localparam logic [TMO_W-1:0] TMO = TMO_W'(TIMEOUT_CYCLES);

  logic dtack_s, berr_s, bg_s, as_in_s;

  sync2 u_sync_dtack (.clk(CLK), .rst(RST), .i_d(DTACK), .o_q(dtack_s));
  sync2 u_sync_berr  (.clk(CLK), .rst(RST), .i_d(BERR),  .o_q(berr_s));
  sync2 u_sync_bg    (.clk(CLK), .rst(RST), .i_d(BG),    .o_q(bg_s));
  sync2 u_sync_as_in (.clk(CLK), .rst(RST), .i_d(AS_IN), .o_q(as_in_s));

  state_t           state_q, state_d;
  logic [TMO_W-1:0] count_q, count_d;
  req_t             req_q, req_d;
  logic             err_flag_q, err_flag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [22:0]      addr_q, addr_d;
  logic [15:0]      data_out_q, data_out_d;
  logic             data_oe_q, data_oe_d;
  logic             bus_oe_q, bus_oe_d;
  logic             as_q, as_d;
  logic             uds_q, uds_d;
  logic             lds_q, lds_d;
  logic             rw_q, rw_d;
  logic [2:0]       fc_q, fc_d;
  logic             br_q, br_d;
  logic             bgack_q, bgack_d;

  logic [TMO_W-1:0] count_inc;

  // Saturating increment: the counter parks at the timeout value, never wraps.
  assign count_inc = (count_q >= TMO) ? TMO : count_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    req_d      = req_q;
    err_flag_d = err_flag_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    bus_oe_d   = bus_oe_q;
    as_d       = as_q;
    uds_d      = uds_q;
    lds_d      = lds_q;
    rw_d       = rw_q;
    fc_d       = FC_CODE;
    br_d       = br_q;
    bgack_d    = bgack_q;

    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          req_d.rw    = REQ_RW;
          req_d.addr  = REQ_ADDR;
          req_d.be    = REQ_BE;
          req_d.wdata = REQ_WDATA;
          req_d.hold  = REQ_HOLD;
          busy_d      = 1'b1;
          err_flag_d  = 1'b0;
          if (REQ_BE == 2'b00) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = ST_REL;
          end else if (!bgack_q) begin
            bus_oe_d = 1'b1;
            addr_d   = REQ_ADDR;
            rw_d     = REQ_RW;
            count_d  = '0;
            state_d  = ST_ADDR;
          end else begin
            br_d    = 1'b0;
            state_d = ST_ARB;
          end
        end
      end

      ST_ARB: begin
        // Take the bus only once the previous master's cycle has fully ended.
        if (!bg_s && as_in_s && dtack_s) begin
          bgack_d  = 1'b0;
          br_d     = 1'b1;
          bus_oe_d = 1'b1;
          addr_d   = req_q.addr;
          rw_d     = req_q.rw;
          count_d  = '0;
          state_d  = ST_ADDR;
        end
      end

      ST_ADDR: begin
        as_d = 1'b0;
        if (req_q.rw) begin
          {uds_d, lds_d} = be_to_ds(req_q.be);
        end else begin
          data_oe_d  = 1'b1;
          data_out_d = req_q.wdata;
        end
        state_d = ST_STROBE;
      end

      ST_STROBE: begin
        if (req_q.rw) begin
          state_d = ST_WAIT;
        end else begin
          {uds_d, lds_d} = be_to_ds(req_q.be);
          state_d        = ST_WDS;
        end
      end

      ST_WDS: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        count_d = count_inc;
        if (!berr_s) begin
          err_flag_d = 1'b1;
          state_d    = ST_END;
        end else if (!dtack_s) begin
          if (req_q.rw) begin
            rdata_d = DATA_IN;
          end
          state_d = ST_END;
        end else if (count_inc >= TMO) begin
          err_flag_d = 1'b1;
          state_d    = ST_END;
        end
        if (state_d == ST_END) begin
          as_d  = 1'b1;
          uds_d = 1'b1;
          lds_d = 1'b1;
        end
      end

      ST_END: begin
        done_d  = 1'b1;
        err_d   = err_flag_q;
        state_d = ST_REL;
      end

      ST_REL: begin
        // Hold data and ownership until the responder has let go of its acks.
        if (dtack_s && berr_s) begin
          data_oe_d = 1'b0;
          rw_d      = 1'b1;
          if (!req_q.hold) begin
            bgack_d  = 1'b1;
            bus_oe_d = 1'b0;
          end
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      req_q      <= '0;
      err_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      bus_oe_q   <= 1'b0;
      as_q       <= 1'b1;
      uds_q      <= 1'b1;
      lds_q      <= 1'b1;
      rw_q       <= 1'b1;
      fc_q       <= FC_CODE;
      br_q       <= 1'b1;
      bgack_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      req_q      <= req_d;
      err_flag_q <= err_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      bus_oe_q   <= bus_oe_d;
      as_q       <= as_d;
      uds_q      <= uds_d;
      lds_q      <= lds_d;
      rw_q       <= rw_d;
      fc_q       <= fc_d;
      br_q       <= br_d;
      bgack_q    <= bgack_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign RDATA    = rdata_q;
  assign ADDR     = addr_q;
  assign DATA_OUT = data_out_q;
  assign DATA_OE  = data_oe_q;
  assign BUS_OE   = bus_oe_q;
  assign AS       = as_q;
  assign UDS      = uds_q;
  assign LDS      = lds_q;
  assign RW       = rw_q;
  assign FC       = fc_q;
  assign BR       = br_q;
  assign BGACK    = bgack_q;

endmodule
`default_nettype wire

// File: tb/tb_m68k_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_m68k_bus_master - directed bench: arbitration, read/write, timeout, hold, reset
// | rev 1.0
// +----------------------------------------------------------------------+
module tb_m68k_bus_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic        REQ_RW = 1'b1;
  logic [22:0] REQ_ADDR = '0;
  logic [1:0]  REQ_BE = 2'b11;
  logic [15:0] REQ_WDATA = '0;
  logic        REQ_HOLD = 1'b0;
  logic [15:0] DATA_IN = '0;
  logic        AS_IN = 1'b1;
  logic        DTACK = 1'b1;
  logic        BERR = 1'b1;
  logic        BG = 1'b1;
  logic        BUSY, DONE, ERR, DATA_OE, BUS_OE, AS, UDS, LDS, RW, BR, BGACK;
  logic [15:0] RDATA, DATA_OUT;
  logic [22:0] ADDR;
  logic [2:0]  FC;

  int checks = 0;
  int failures = 0;
  bit wait_ok;
  bit strobe_seen, br_seen, done_seen;

  m68k_bus_master #(.TIMEOUT_CYCLES(16), .FC_CODE(3'b101)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_RW(REQ_RW), .REQ_ADDR(REQ_ADDR),
    .REQ_BE(REQ_BE), .REQ_WDATA(REQ_WDATA), .REQ_HOLD(REQ_HOLD),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA), .ADDR(ADDR),
    .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN), .DATA_OE(DATA_OE), .BUS_OE(BUS_OE),
    .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .FC(FC), .AS_IN(AS_IN),
    .DTACK(DTACK), .BERR(BERR), .BR(BR), .BG(BG), .BGACK(BGACK)
  );

  always #5 CLK = ~CLK;

  // Every sample point is 1 ns after a rising edge; activity flags collect there.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (AS !== 1'b1 || UDS !== 1'b1 || LDS !== 1'b1) strobe_seen = 1'b1;
    if (BR !== 1'b1) br_seen = 1'b1;
    if (DONE === 1'b1) done_seen = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic rw, input logic [22:0] a, input logic [1:0] be,
                       input logic [15:0] wd, input logic hold);
    REQ_RW = rw; REQ_ADDR = a; REQ_BE = be; REQ_WDATA = wd; REQ_HOLD = hold;
    REQ = 1'b1;
    tick();
    REQ = 1'b0;
  endtask

  task automatic wait_bgack(input int limit);
    int n = 0;
    while (BGACK !== 1'b0 && n < limit) begin tick(); n++; end
    wait_ok = (BGACK === 1'b0);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (DONE !== 1'b1 && n < limit) begin tick(); n++; end
    wait_ok = (DONE === 1'b1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (BUSY !== 1'b0 && n < limit) begin tick(); n++; end
    wait_ok = (BUSY === 1'b0);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    ticks(3);
    checks++; if ({AS, UDS, LDS, RW, BR, BGACK, BUS_OE, DATA_OE, BUSY, DONE, ERR} !== 11'b111111_00000) begin
      failures++; $display("FAIL reset_ctl got=%b exp=%b", {AS, UDS, LDS, RW, BR, BGACK, BUS_OE, DATA_OE, BUSY, DONE, ERR}, 11'b111111_00000); end
    checks++; if ({RDATA, ADDR, DATA_OUT} !== 55'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {RDATA, ADDR, DATA_OUT}); end
    checks++; if (FC !== 3'b101) begin failures++; $display("FAIL reset_fc got=%b exp=101", FC); end
    RST = 1'b0;
    ticks(2);
  endtask

  task automatic test_read();
    BG = 1'b0; AS_IN = 1'b1;
    ticks(3);
    issue(1'b1, 23'h080000, 2'b11, 16'h0000, 1'b0);
    checks++; if ({BUSY, BR} !== 2'b10) begin failures++; $display("FAIL rd_accept busy_br got=%b exp=10", {BUSY, BR}); end
    wait_bgack(10);
    checks++; if (!wait_ok) begin failures++; $display("FAIL rd_bgack got=%b exp=0", BGACK); end
    checks++; if ({BR, BUS_OE, RW, AS, ADDR} !== {4'b1111, 23'h080000}) begin
      failures++; $display("FAIL rd_addr_phase got=%b_%h exp=1111_080000", {BR, BUS_OE, RW, AS}, ADDR); end
    tick();
    checks++; if ({AS, UDS, LDS, DATA_OE} !== 4'b0000) begin
      failures++; $display("FAIL rd_strobes got=%b exp=0000", {AS, UDS, LDS, DATA_OE}); end
    ticks(3);
    DTACK = 1'b0; DATA_IN = 16'hBEEF;
    ticks(3);
    checks++; if ({AS, UDS, LDS, DONE} !== 4'b1110) begin
      failures++; $display("FAIL rd_end got=%b exp=1110", {AS, UDS, LDS, DONE}); end
    tick();
    checks++; if ({DONE, ERR, RDATA} !== {2'b10, 16'hBEEF}) begin
      failures++; $display("FAIL rd_done got=%b_%h exp=10_beef", {DONE, ERR}, RDATA); end
    DTACK = 1'b1;
    tick();
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL rd_done_pulse got=%b exp=0", DONE); end
    wait_idle(10);
    checks++; if (!wait_ok || {BGACK, BUS_OE, BR, DATA_OE, RW} !== 5'b10101) begin
      failures++; $display("FAIL rd_release got=%b exp=10101", {BGACK, BUS_OE, BR, DATA_OE, RW}); end
  endtask

  task automatic test_write();
    issue(1'b0, 23'h000100, 2'b01, 16'h1234, 1'b0);
    wait_bgack(10);
    checks++; if (!wait_ok || {AS, RW, BUS_OE} !== 3'b101) begin
      failures++; $display("FAIL wr_addr_phase got=%b exp=101", {AS, RW, BUS_OE}); end
    tick();
    checks++; if ({AS, UDS, LDS, DATA_OE, DATA_OUT} !== {4'b0111, 16'h1234}) begin
      failures++; $display("FAIL wr_as_data got=%b_%h exp=0111_1234", {AS, UDS, LDS, DATA_OE}, DATA_OUT); end
    tick();
    checks++; if ({AS, UDS, LDS} !== 3'b010) begin
      failures++; $display("FAIL wr_ds got=%b exp=010", {AS, UDS, LDS}); end
    DTACK = 1'b0;
    wait_done(12);
    checks++; if (!wait_ok || ERR !== 1'b0) begin
      failures++; $display("FAIL wr_done done_err got=%b%b exp=10", DONE, ERR); end
    DTACK = 1'b1;
    wait_idle(10);
    checks++; if (!wait_ok || {BGACK, BUS_OE, DATA_OE} !== 3'b100) begin
      failures++; $display("FAIL wr_release got=%b exp=100", {BGACK, BUS_OE, DATA_OE}); end
  endtask

  task automatic test_arbitration();
    BG = 1'b1; AS_IN = 1'b0;
    ticks(3);
    issue(1'b1, 23'h000200, 2'b11, 16'h0000, 1'b0);
    ticks(5);
    checks++; if ({BR, BGACK} !== 2'b01) begin failures++; $display("FAIL arb_no_grant got=%b exp=01", {BR, BGACK}); end
    BG = 1'b0;
    ticks(6);
    checks++; if ({BR, BGACK} !== 2'b01) begin failures++; $display("FAIL arb_as_busy got=%b exp=01", {BR, BGACK}); end
    AS_IN = 1'b1;
    wait_bgack(10);
    checks++; if (!wait_ok || BR !== 1'b1) begin failures++; $display("FAIL arb_take got=%b%b exp=10", BGACK, BR); end
    DTACK = 1'b0; DATA_IN = 16'h5A5A;
    wait_done(12);
    checks++; if (!wait_ok || {ERR, RDATA} !== {1'b0, 16'h5A5A}) begin
      failures++; $display("FAIL arb_done got=%b_%h exp=0_5a5a", ERR, RDATA); end
    DTACK = 1'b1;
    wait_idle(10);
  endtask

  task automatic test_timeout();
    issue(1'b1, 23'h000300, 2'b10, 16'h0000, 1'b0);
    wait_bgack(10);
    checks++; if (!wait_ok) begin failures++; $display("FAIL tmo_bgack got=%b exp=0", BGACK); end
    ticks(17);
    checks++; if ({AS, UDS, LDS, DONE} !== 4'b0010) begin
      failures++; $display("FAIL tmo_still_wait got=%b exp=0010", {AS, UDS, LDS, DONE}); end
    tick();
    checks++; if ({AS, UDS, LDS, DONE} !== 4'b1110) begin
      failures++; $display("FAIL tmo_negate got=%b exp=1110", {AS, UDS, LDS, DONE}); end
    tick();
    checks++; if ({DONE, ERR} !== 2'b11) begin failures++; $display("FAIL tmo_err got=%b exp=11", {DONE, ERR}); end
    wait_idle(10);
  endtask

  task automatic test_berr_priority();
    issue(1'b1, 23'h000400, 2'b11, 16'h0000, 1'b0);
    wait_bgack(10);
    tick();
    DTACK = 1'b0; BERR = 1'b0;
    wait_done(12);
    checks++; if (!wait_ok || ERR !== 1'b1) begin failures++; $display("FAIL berr_dtack got=%b%b exp=11", DONE, ERR); end
    DTACK = 1'b1; BERR = 1'b1;
    wait_idle(10);
    checks++; if (!wait_ok || BGACK !== 1'b1) begin failures++; $display("FAIL berr_release got=%b exp=1", BGACK); end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 23'h000500, 2'b11, 16'h0000, 1'b1);
    wait_bgack(10);
    tick();
    DTACK = 1'b0; DATA_IN = 16'h1111;
    wait_done(12);
    DTACK = 1'b1;
    wait_idle(10);
    checks++; if (!wait_ok || {BGACK, BUS_OE, BR, RW} !== 4'b0111) begin
      failures++; $display("FAIL hold_kept got=%b exp=0111", {BGACK, BUS_OE, BR, RW}); end
    BG = 1'b1;
    br_seen = 1'b0;
    ticks(3);
    issue(1'b1, 23'h000600, 2'b11, 16'h0000, 1'b0);
    checks++; if ({BGACK, BUS_OE, AS, ADDR} !== {3'b011, 23'h000600}) begin
      failures++; $display("FAIL hold_direct_addr got=%b_%h exp=011_000600", {BGACK, BUS_OE, AS}, ADDR); end
    tick();
    checks++; if (AS !== 1'b0) begin failures++; $display("FAIL hold_strobe got=%b exp=0", AS); end
    DTACK = 1'b0; DATA_IN = 16'h2222;
    wait_done(12);
    checks++; if (!wait_ok || {ERR, RDATA} !== {1'b0, 16'h2222}) begin
      failures++; $display("FAIL hold_second got=%b_%h exp=0_2222", ERR, RDATA); end
    DTACK = 1'b1;
    wait_idle(10);
    checks++; if ({br_seen, BGACK, BUS_OE} !== 3'b010) begin
      failures++; $display("FAIL hold_no_br got=%b exp=010", {br_seen, BGACK, BUS_OE}); end
  endtask

  task automatic test_bad_be();
    strobe_seen = 1'b0; br_seen = 1'b0;
    issue(1'b1, 23'h000700, 2'b00, 16'h0000, 1'b0);
    checks++; if ({BUSY, DONE, ERR} !== 3'b111) begin
      failures++; $display("FAIL be00_done got=%b exp=111", {BUSY, DONE, ERR}); end
    tick();
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL be00_pulse got=%b exp=0", DONE); end
    wait_idle(5);
    checks++; if (!wait_ok || {strobe_seen, br_seen, BUS_OE} !== 3'b000) begin
      failures++; $display("FAIL be00_no_bus got=%b exp=000", {strobe_seen, br_seen, BUS_OE}); end
  endtask

  task automatic test_reset_mid_cycle();
    BG = 1'b0;
    ticks(3);
    issue(1'b1, 23'h000800, 2'b11, 16'h0000, 1'b0);
    wait_bgack(10);
    ticks(4);
    checks++; if (AS !== 1'b0) begin failures++; $display("FAIL rst_pre_wait got=%b exp=0", AS); end
    done_seen = 1'b0;
    RST = 1'b1;
    tick();
    checks++; if ({AS, UDS, LDS, BGACK, BR, BUS_OE, DATA_OE, BUSY, DONE} !== 9'b111110000) begin
      failures++; $display("FAIL rst_mid got=%b exp=111110000", {AS, UDS, LDS, BGACK, BR, BUS_OE, DATA_OE, BUSY, DONE}); end
    RST = 1'b0;
    ticks(5);
    checks++; if (done_seen !== 1'b0) begin failures++; $display("FAIL rst_no_done got=%b exp=0", done_seen); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_arbitration();
    test_timeout();
    test_berr_priority();
    test_back_to_back();
    test_bad_be();
    test_reset_mid_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
